logic_threshold_rx: RTL and testbench

Receive-side logic threshold detector for the mixed-signal logic models. It turns a stream of sampled node-voltage codes into a clean logic level using high/low thresholds (thh/thl) with hysteresis and a consecutive-sample deglitch delay. It emits single-cycle rise/fall strobes and flags samples in the undefined band. It sits between an ADC/sampler front end and digital consumers, and is the input-side counterpart to the logic gate output driver.

---
 rtl/logic_threshold_rx.sv | 145 ++++++++++++++
 tb/tb_logic_threshold_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_threshold_rx.sv
// Receive-side logic threshold detector: hysteresis thresholds plus a consecutive-sample
// deglitch delay. Optional rejected-transition counter under LOGIC_RX_GLITCH_CNT_EN.
module logic_threshold_rx #(
  parameter int W     = 12,
  parameter int TH_HI = 3686,
  parameter int TH_LO = 409,
  parameter int DELAY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_valid,
  input  logic [W-1:0] sample,
  output logic         level,
  output logic         rise,
  output logic         fall,
  output logic         undef,
`ifdef LOGIC_RX_GLITCH_CNT_EN
  output logic [15:0]  glitch_cnt,
`endif
  output logic [1:0]   state_dbg
);

  // sample_valid qualifies sample for one cycle; there is no ready, every valid sample is consumed.

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } state_t;

  localparam logic [W-1:0] TH_HI_C = W'(TH_HI);
  localparam logic [W-1:0] TH_LO_C = W'(TH_LO);
  localparam logic [7:0]   DELAY_C = 8'(DELAY);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       is_hi;
  logic       is_lo;
  logic       is_mid;

  assign is_hi     = (sample >= TH_HI_C);
  assign is_lo     = (sample <= TH_LO_C);
  assign is_mid    = !is_hi && !is_lo;
  assign cnt_inc   = cnt + 8'd1;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOW;
      cnt   <= 8'd0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      undef <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sample_valid) begin
        undef <= is_mid;
        // Mid-band samples fall through every branch: they neither start nor cancel a transition.
        case (state)
          ST_LOW: begin
            if (is_hi) begin
              if (DELAY_C == 8'd1) begin
                state <= ST_HIGH;
                level <= 1'b1;
                rise  <= 1'b1;
                cnt   <= 8'd0;
              end else begin
                state <= ST_RISE_PEND;
                cnt   <= 8'd1;
              end
            end
          end
          ST_RISE_PEND: begin
            if (is_hi) begin
              if (cnt_inc == DELAY_C) begin
                state <= ST_HIGH;
                level <= 1'b1;
                rise  <= 1'b1;
                cnt   <= 8'd0;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (is_lo) begin
              state <= ST_LOW;
              cnt   <= 8'd0;
            end
          end
          ST_HIGH: begin
            if (is_lo) begin
              if (DELAY_C == 8'd1) begin
                state <= ST_LOW;
                level <= 1'b0;
                fall  <= 1'b1;
                cnt   <= 8'd0;
              end else begin
                state <= ST_FALL_PEND;
                cnt   <= 8'd1;
              end
            end
          end
          ST_FALL_PEND: begin
            if (is_lo) begin
              if (cnt_inc == DELAY_C) begin
                state <= ST_LOW;
                level <= 1'b0;
                fall  <= 1'b1;
                cnt   <= 8'd0;
              end else begin
                cnt <= cnt_inc;
              end
            end else if (is_hi) begin
              state <= ST_HIGH;
              cnt   <= 8'd0;
            end
          end
          default: begin
            state <= ST_LOW;
            cnt   <= 8'd0;
          end
        endcase
      end
    end
  end

`ifdef LOGIC_RX_GLITCH_CNT_EN
  logic abort;

  assign abort = sample_valid &&
                 (((state == ST_RISE_PEND) && is_lo) || ((state == ST_FALL_PEND) && is_hi));

  // Saturating so a noisy line cannot wrap the count back to a small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= 16'd0;
    end else if (abort && (glitch_cnt != 16'hFFFF)) begin
      glitch_cnt <= glitch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_threshold_rx.sv
// Bench for logic_threshold_rx: a DELAY=4 and a DELAY=1 instance share stimulus and are
// compared every cycle against a run-length model, plus directed literal checks.
module tb_logic_threshold_rx;

  localparam int W = 12;

  logic         clk;
  logic         rst_n;
  logic         sample_valid;
  logic [W-1:0] sample;

  logic         level_a, rise_a, fall_a, undef_a;
  logic         level_b, rise_b, fall_b, undef_b;
  logic [1:0]   state_a, state_b;
  logic [15:0]  glitch_a, glitch_b;

  int n_checks;
  int n_errors;

  logic [W-1:0] exp_q[$];

  // model state per instance: index 0 = DELAY 4, index 1 = DELAY 1
  int   m_delay [2];
  logic m_level [2];
  logic m_rise  [2];
  logic m_fall  [2];
  logic m_undef [2];
  int   m_run   [2];
  int   m_glitch[2];

  logic [W-1:0] rs;
  int           cls;
  int           len;

  logic_threshold_rx #(.W(W), .TH_HI(3686), .TH_LO(409), .DELAY(4)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (level_a),
    .rise         (rise_a),
    .fall         (fall_a),
    .undef        (undef_a),
`ifdef LOGIC_RX_GLITCH_CNT_EN
    .glitch_cnt   (glitch_a),
`endif
    .state_dbg    (state_a)
  );

  logic_threshold_rx #(.W(W), .TH_HI(3686), .TH_LO(409), .DELAY(1)) u_fast (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .level        (level_b),
    .rise         (rise_b),
    .fall         (fall_b),
    .undef        (undef_b),
`ifdef LOGIC_RX_GLITCH_CNT_EN
    .glitch_cnt   (glitch_b),
`endif
    .state_dbg    (state_b)
  );

`ifndef LOGIC_RX_GLITCH_CNT_EN
  assign glitch_a = 16'd0;
  assign glitch_b = 16'd0;
`endif

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: a transition commits after DELAY consecutive valid samples on the
  // opposite side of the committed level; a same-side sample cancels the run.
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_level[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
      m_undef[i] = 1'b0; m_run[i] = 0; m_glitch[i] = 0;
    end
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] s);
    logic hi, lo;
    hi = (s >= 3686);
    lo = (s <= 409);
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (v) begin
        m_undef[i] = !hi && !lo;
        if (hi || lo) begin
          if (hi == m_level[i]) begin
            if (m_run[i] > 0 && m_glitch[i] < 65535) m_glitch[i]++;
            m_run[i] = 0;
          end else begin
            m_run[i]++;
            if (m_run[i] == m_delay[i]) begin
              m_level[i] = hi;
              m_rise[i]  = hi;
              m_fall[i]  = lo;
              m_run[i]   = 0;
            end
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step(sample_valid, sample);
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    check("level_d4", level_a, m_level[0]);
    check("rise_d4",  rise_a,  m_rise[0]);
    check("fall_d4",  fall_a,  m_fall[0]);
    check("undef_d4", undef_a, m_undef[0]);
    check("level_d1", level_b, m_level[1]);
    check("rise_d1",  rise_b,  m_rise[1]);
    check("fall_d1",  fall_b,  m_fall[1]);
    check("undef_d1", undef_b, m_undef[1]);
    check("excl_d4",  rise_a & fall_a, 1'b0);
    check("excl_d1",  rise_b & fall_b, 1'b0);
`ifdef LOGIC_RX_GLITCH_CNT_EN
    check("glitch_d4", glitch_a, m_glitch[0]);
    check("glitch_d1", glitch_b, m_glitch[1]);
`endif
  end

  // driver: present one sample, let the next rising edge capture it
  task automatic step(input logic v, input logic [W-1:0] s);
    sample_valid = v;
    sample       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_level_d4", level_a, 1'b0);
    check("rst_state_d4", state_a, 2'd0);
    check("rst_level_d1", level_b, 1'b0);
    check("rst_undef_d4", undef_a, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_delay[0] = 4;
    m_delay[1] = 1;
    model_reset();
    rst_n = 1'b0;
    sample_valid = 1'b0;
    sample = '0;
    repeat (2) @(posedge clk);
    #1;
    check("por_level", level_a, 1'b0);
    check("por_rise",  rise_a,  1'b0);
    check("por_fall",  fall_a,  1'b0);
    check("por_undef", undef_a, 1'b0);
    check("por_glitch", glitch_a, 16'd0);
    rst_n = 1'b1;

    // ten hi samples: commit on the 4th
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 12'd4000);
      check("hi_run_level", level_a, (i >= 4));
      check("hi_run_rise",  rise_a,  (i == 4));
      check("hi_run_undef", undef_a, 1'b0);
    end

    // fall through the mid band
    exp_q = '{12'd100, 12'd100, 12'd2000, 12'd2000, 12'd100, 12'd100};
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, exp_q.pop_front());
      check("fall_seq_level", level_a, (i < 6));
      check("fall_seq_fall",  fall_a,  (i == 6));
      check("fall_seq_undef", undef_a, (i == 3 || i == 4));
    end

    // aborted rise
    step(1'b1, 12'd4000);
    step(1'b1, 12'd4000);
    step(1'b1, 12'd4000);
    check("abort_state", state_a, 2'd1);
    step(1'b1, 12'd100);
    check("abort_level", level_a, 1'b0);
    check("abort_rise",  rise_a,  1'b0);
`ifdef LOGIC_RX_GLITCH_CNT_EN
    check("abort_glitch", glitch_a, 16'd1);
`endif

    // hi samples interleaved with ignored invalid cycles
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 12'd4000);
      check("gap_rise",  rise_a,  (i == 4));
      check("gap_level", level_a, (i == 4));
      step(1'b0, 12'd100);
      check("gap_inv_level", level_a, (i == 4));
      check("gap_inv_rise",  rise_a,  1'b0);
      check("gap_inv_undef", undef_a, 1'b0);
    end

    // DELAY=1 toggles on every valid sample
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i % 2 == 0) ? 12'd100 : 12'd4000);
      check("fast_level", level_b, (i % 2 == 1));
      check("fast_rise",  rise_b,  (i % 2 == 1));
      check("fast_fall",  fall_b,  (i % 2 == 0));
    end
    check("fast_glitch", glitch_b, 16'd0);

    // reset mid-pending: drive to RISE_PEND with cnt=3 first
    do_reset();
    step(1'b1, 12'd4000);
    step(1'b1, 12'd4000);
    step(1'b1, 12'd4000);
    check("pend_state", state_a, 2'd1);
    check("pend_fast_level", level_b, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 12'd4000);
      check("post_rst_rise",  rise_a,  1'b0);
      check("post_rst_level", level_a, 1'b0);
    end

    // randomized bursts of each class, including the exact threshold codes
    for (int b = 0; b < 400; b++) begin
      cls = $urandom_range(0, 2);
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        case (cls)
          0:       rs = ($urandom_range(0, 3) == 0) ? 12'd409  : 12'($urandom_range(0, 409));
          1:       rs = ($urandom_range(0, 3) == 0) ? 12'd410  : 12'($urandom_range(410, 3685));
          default: rs = ($urandom_range(0, 3) == 0) ? 12'd3686 : 12'($urandom_range(3686, 4095));
        endcase
        if (cls == 1 && $urandom_range(0, 1) == 1) rs = 12'd3685;
        step($urandom_range(0, 3) != 0, rs);
      end
      if (b == 200) do_reset();
    end

    step(1'b0, 12'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
